// File: rtl/sop_shared_cfg_eval_if.sv
// Bus bundle for the shared-product SOP evaluator: config stream, input vectors,
// results, and debug visibility of the control FSM.
interface sop_shared_cfg_eval_if #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int N_PROD = 6
);
    localparam int CW    = (2 * N_IN > N_PROD) ? 2 * N_IN : N_PROD;
    localparam int IDX_W = $clog2(N_PROD + N_OUT);

    // Every channel transfers a word on a rising edge where valid and ready are both high;
    // a producer holds valid and its data stable until that edge, and ready never waits on valid.
    logic              cfg_start;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CW-1:0]     cfg_data;
    logic              cfg_err;
    logic              run;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic [2:0]        dbg_state;
    logic [IDX_W-1:0]  dbg_idx;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, cfg_err, run, in_ready, out_valid, out_data, dbg_state, dbg_idx
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, cfg_err, run, in_ready, out_valid, out_data, dbg_state, dbg_idx
    );
endinterface

// File: rtl/sop_shared_cfg_eval.sv
// Runtime-loadable shared-product SOP evaluator: config words set literal masks and
// output activations, a check stage rejects over-sized terms, then a 2-stage pipeline evaluates.
module sop_shared_cfg_eval #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int N_PROD = 6,
    parameter int LPP    = 3,
    parameter int PPO    = 3
) (
    input  logic clk,
    input  logic rst_n,
    sop_shared_cfg_eval_if.slave bus
);
    localparam int CW    = (2 * N_IN > N_PROD) ? 2 * N_IN : N_PROD;
    localparam int NW    = N_PROD + N_OUT;
    localparam int IDX_W = $clog2(NW);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_IN-1:0]   pos_q [N_PROD];
    logic [N_IN-1:0]   pos_d [N_PROD];
    logic [N_IN-1:0]   neg_q [N_PROD];
    logic [N_IN-1:0]   neg_d [N_PROD];
    logic [N_PROD-1:0] act_q [N_OUT];
    logic [N_PROD-1:0] act_d [N_OUT];
    logic              cfg_ready_q, cfg_ready_d;
    logic              run_q, run_d;
    logic              cfg_err_q, cfg_err_d;
    logic              s1_valid_q, s1_valid_d;
    logic [N_PROD-1:0] prod_q, prod_d;
    logic              out_valid_q, out_valid_d;
    logic [N_OUT-1:0]  out_data_q, out_data_d;

    logic              cfg_fire;
    logic              cfg_legal;
    logic              en;
    logic              in_ready;
    logic              in_fire;
    logic [N_PROD-1:0] prod_calc;
    logic [N_OUT-1:0]  out_calc;

    function automatic int popcnt(input logic [CW-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < CW; i++) c += int'(v[i]);
        return c;
    endfunction

    assign cfg_fire = bus.cfg_valid & cfg_ready_q & ~bus.cfg_start;
    assign en       = ~out_valid_q | bus.out_ready;
    assign in_ready = run_q & en & ~bus.cfg_start;
    assign in_fire  = bus.in_valid & in_ready;

    always_comb begin
        cfg_legal = 1'b1;
        for (int p = 0; p < N_PROD; p++)
            if (popcnt(CW'(pos_q[p] | neg_q[p])) > LPP) cfg_legal = 1'b0;
        for (int j = 0; j < N_OUT; j++)
            if (popcnt(CW'(act_q[j])) > PPO) cfg_legal = 1'b0;
    end

    // A literal set in both masks makes its product unsatisfiable, so it evaluates to 0.
    always_comb begin
        prod_calc = '0;
        out_calc  = '0;
        for (int p = 0; p < N_PROD; p++)
            prod_calc[p] = (&(bus.in_data | ~pos_q[p])) & (&(~bus.in_data | ~neg_q[p]));
        for (int j = 0; j < N_OUT; j++)
            out_calc[j] = |(prod_q & act_q[j]);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        act_d   = act_q;
        for (int p = 0; p < N_PROD; p++) begin
            if (cfg_fire && idx_q == IDX_W'(p)) begin
                pos_d[p] = bus.cfg_data[N_IN-1:0];
                neg_d[p] = bus.cfg_data[2*N_IN-1:N_IN];
            end
        end
        for (int j = 0; j < N_OUT; j++)
            if (cfg_fire && idx_q == IDX_W'(N_PROD + j)) act_d[j] = bus.cfg_data[N_PROD-1:0];

        if (bus.cfg_start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (cfg_fire) begin
                        if (idx_q == IDX_W'(NW - 1)) begin
                            state_d = ST_CHECK;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: state_d = cfg_legal ? ST_RUN : ST_ERR;
                default:  state_d = state_q;
            endcase
        end

        cfg_ready_d = (state_d == ST_LOAD);
        run_d       = (state_d == ST_RUN);
        cfg_err_d   = (state_d == ST_ERR);
    end

    // Both stages advance together on en, so a stalled output freezes the whole pipe.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (bus.cfg_start) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (en) begin
            s1_valid_d  = in_fire;
            out_valid_d = s1_valid_q;
            if (in_fire)    prod_d     = prod_calc;
            if (s1_valid_q) out_data_d = out_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pos_q       <= '{default: '0};
            neg_q       <= '{default: '0};
            act_q       <= '{default: '0};
            cfg_ready_q <= 1'b0;
            run_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            act_q       <= act_d;
            cfg_ready_q <= cfg_ready_d;
            run_q       <= run_d;
            cfg_err_q   <= cfg_err_d;
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.run       = run_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_idx   = idx_q;
endmodule

// File: tb/tb_sop_shared_cfg_eval.sv
// Bench for sop_shared_cfg_eval: directed config/pipeline scenarios plus random configs and
// random streams scored against a loop-based SOP reference model.
module tb_sop_shared_cfg_eval;
    localparam int N_IN = 4, N_OUT = 3, N_PROD = 6, LPP = 3, PPO = 3;
    localparam int CW = 8, NW = N_PROD + N_OUT;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sop_shared_cfg_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PROD(N_PROD)) bus ();

    sop_shared_cfg_eval #(
        .N_IN(N_IN), .N_OUT(N_OUT), .N_PROD(N_PROD), .LPP(LPP), .PPO(PPO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [CW-1:0] cfg_w [NW];
    logic [N_OUT-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: products and outputs straight from the mask definitions
    function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] v);
        logic [N_OUT-1:0] r;
        bit term;
        r = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int p = 0; p < N_PROD; p++) begin
                if (cfg_w[N_PROD + j][p]) begin
                    term = 1;
                    for (int i = 0; i < N_IN; i++) begin
                        if (cfg_w[p][i] && !v[i]) term = 0;
                        if (cfg_w[p][N_IN + i] && v[i]) term = 0;
                    end
                    if (term) r[j] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic bit model_legal();
        int lits, prods;
        bit ok;
        ok = 1;
        for (int p = 0; p < N_PROD; p++) begin
            lits = 0;
            for (int i = 0; i < N_IN; i++)
                if (cfg_w[p][i] || cfg_w[p][N_IN + i]) lits++;
            if (lits > LPP) ok = 0;
        end
        for (int j = 0; j < N_OUT; j++) begin
            prods = 0;
            for (int p = 0; p < N_PROD; p++)
                if (cfg_w[N_PROD + j][p]) prods++;
            if (prods > PPO) ok = 0;
        end
        return ok;
    endfunction

    // scoreboard: inputs accepted push a prediction, results delivered pop one
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
                else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
            if (bus.cfg_start) exp_q.delete();
            else if (bus.in_valid && bus.in_ready) exp_q.push_back(model_eval(bus.in_data));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_legal_cfg();
        cfg_w[0] = 8'h0C; cfg_w[1] = 8'h0A; cfg_w[2] = 8'h20;
        cfg_w[3] = 8'h01; cfg_w[4] = 8'h10; cfg_w[5] = 8'h00;
        cfg_w[6] = 8'h07; cfg_w[7] = 8'h30; cfg_w[8] = 8'h00;
    endtask

    task automatic load_cfg(input string tag);
        int guard;
        bit legal;
        legal = model_legal();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check({tag, "_idx_start"}, 32'(bus.dbg_idx), 32'd0);
        for (int w = 0; w < NW; w++) begin
            repeat ($urandom_range(0, 1)) begin
                bus.cfg_data = 8'($urandom);
                tick();
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = cfg_w[w];
            guard = 0;
            while (!bus.cfg_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard == 20) check({tag, "_cfg_ready_timeout"}, 32'(bus.cfg_ready), 32'd1);
            tick();
            bus.cfg_valid = 1'b0;
        end
        check({tag, "_check_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
        check({tag, "_check_run"}, 32'(bus.run), 32'd0);
        tick();
        check({tag, "_run"}, 32'(bus.run), 32'(legal));
        check({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'(!legal));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(legal));
    endtask

    task automatic rand_stream(input string tag, input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [N_IN-1:0] vecs [3];
        int k, guard;
        bit fire;

        bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
        bus.in_valid  = 1'b0; bus.in_data   = '0;   bus.out_ready = 1'b1;
        #12;
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("rst_run", 32'(bus.run), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        check("rst_idx", 32'(bus.dbg_idx), 32'd0);
        tick();
        rst_n = 1'b1;

        // config words offered outside LOAD are ignored
        bus.cfg_valid = 1'b1; bus.cfg_data = 8'h0F;
        tick(); tick();
        bus.cfg_valid = 1'b0;
        check("idle_cfg_ignored_idx", 32'(bus.dbg_idx), 32'd0);
        check("idle_cfg_ready", 32'(bus.cfg_ready), 32'd0);

        set_legal_cfg();
        load_cfg("legal1");

        // first-result latency
        bus.in_valid = 1'b1; bus.in_data = 4'b0000;
        check("lat_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_out_data", 32'(bus.out_data), 32'b011);
        tick();

        // back-to-back vectors
        bus.in_valid = 1'b1; bus.in_data = 4'b0010;
        tick();
        bus.in_data = 4'b1100;
        tick();
        bus.in_valid = 1'b0;
        check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_first_data", 32'(bus.out_data), 32'b010);
        tick();
        check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_second_data", 32'(bus.out_data), 32'b011);
        tick();
        check("b2b_done", 32'(bus.out_valid), 32'd0);

        // backpressure: only two vectors fit while the output is stalled
        vecs[0] = 4'b0000; vecs[1] = 4'b0010; vecs[2] = 4'b1100;
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (k < 3);
            if (k < 3) bus.in_data = vecs[k];
            fire = bus.in_valid && bus.in_ready;
            tick();
            if (fire) k++;
        end
        check("stall_accepted", 32'(k), 32'd2);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'b011);
        tick(); tick();
        check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold_data", 32'(bus.out_data), 32'b011);
        bus.out_ready = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 10) begin
            tick();
            guard++;
        end
        check("stall_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // flush with two results in flight
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 4'b0010;
        tick();
        bus.in_data = 4'b1100;
        tick();
        bus.in_valid = 1'b0;
        check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("flush_none_emitted", 32'(bus.out_valid), 32'd0);
        end
        load_cfg("legal2");
        rand_stream("legal2", 40);

        // too many products on one output
        cfg_w[N_PROD] = 8'h0F;
        load_cfg("ppo_err");
        bus.in_valid = 1'b1; bus.in_data = 4'b0000;
        tick();
        bus.in_valid = 1'b0;
        check("ppo_err_sticky", 32'(bus.cfg_err), 32'd1);
        check("ppo_no_output", 32'(bus.out_valid), 32'd0);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check("restart_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("restart_cfg_ready", 32'(bus.cfg_ready), 32'd1);

        // too many literals in one product, then recover
        set_legal_cfg();
        cfg_w[0] = 8'h0F;
        load_cfg("lpp_err");
        set_legal_cfg();
        load_cfg("legal3");
        rand_stream("legal3", 40);

        // restart mid-load, then async reset mid-load
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_data = 8'h12;
        tick(); tick(); tick();
        bus.cfg_valid = 1'b0;
        check("midload_idx", 32'(bus.dbg_idx), 32'd3);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check("restart_idx", 32'(bus.dbg_idx), 32'd0);
        bus.cfg_valid = 1'b1;
        tick(); tick();
        bus.cfg_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("arst_state", 32'(bus.dbg_state), 32'd0);
        check("arst_idx", 32'(bus.dbg_idx), 32'd0);
        check("arst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        rst_n = 1'b1;

        // random configurations, streamed when legal
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < NW; w++) cfg_w[w] = 8'($urandom & $urandom);
            load_cfg("rand_cfg");
            if (model_legal()) rand_stream("rand_cfg", 60);
        end

        set_legal_cfg();
        load_cfg("legal_final");
        rand_stream("legal_final", 60);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
